// File: rtl/lane_judge.sv
`timescale 1ns/1ps
// lane_judge -- per-lane note scheduler and hit judge.
//
// Walks one lane's chart ROM, counts song time in frames, and judges key
// presses against the head note. It emits one PERFECT/GOOD/MISS result per
// note and keeps the lane's combo count.
//
// Ports
//   Clk, Reset_n      clock, async active-low reset
//   frame_tick        60 Hz single-cycle strobe, advances song_time
//   start             starts/restarts the chart (honoured in IDLE/DONE only)
//   key_in            lane key level, synchronous to Clk
//   key_1, key_2      combinational ROM data at addr / addr+1
//   addr              ROM address of the head note
//   song_time         frames since start
//   judge_valid       one-cycle pulse per judgement
//   judge_code        01 PERFECT, 10 GOOD, 11 MISS (held between pulses)
//   combo             consecutive hit count, saturating at 1023
//   hold_active       high while a hold note is held
//   done              high once the chart has finished
module lane_judge #(
    parameter int PERFECT_WIN = 3,
    parameter int GOOD_WIN    = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        key_in,
    input  logic [15:0] key_1,
    input  logic [15:0] key_2,
    output logic [7:0]  addr,
    output logic [13:0] song_time,
    output logic        judge_valid,
    output logic [1:0]  judge_code,
    output logic [9:0]  combo,
    output logic        hold_active,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_DONE} state_t;

    localparam logic [1:0] J_PERFECT = 2'b01;
    localparam logic [1:0] J_GOOD    = 2'b10;
    localparam logic [1:0] J_MISS    = 2'b11;

    localparam logic [1:0] T_HSTART  = 2'b01;
    localparam logic [1:0] T_HEND    = 2'b10;

    localparam logic        [14:0] PW_U  = 15'(PERFECT_WIN);
    localparam logic        [14:0] GW_U  = 15'(GOOD_WIN);
    localparam logic signed [14:0] GW_S  = 15'(GOOD_WIN);
    localparam logic signed [14:0] NGW_S = -GW_S;

    state_t state;
    logic   key_q;

    // The partner hold-end always sits at addr+1, so skipping it needs only
    // the address, not the entry contents.
    logic unused_key_2;
    assign unused_key_2 = ^key_2;

    // Head note decode and timing delta
    logic        [1:0]  head_type;
    logic        [13:0] head_t;
    logic signed [14:0] delta;
    logic        [14:0] abs_d;
    logic               is_late, in_good, in_perf, press;
    logic        [1:0]  win_code;

    assign head_type = key_1[15:14];
    assign head_t    = key_1[13:0];
    assign delta     = $signed({1'b0, song_time}) - $signed({1'b0, head_t});
    assign abs_d     = delta[14] ? $unsigned(-delta) : $unsigned(delta);
    assign is_late   = delta > GW_S;
    assign in_good   = abs_d <= GW_U;
    assign in_perf   = abs_d <= PW_U;
    assign press     = key_in & ~key_q;
    assign win_code  = in_perf ? J_PERFECT : J_GOOD;

    // Per-cycle decision: at most one judgement and one advance.
    logic       do_judge, go_hold, go_done;
    logic [1:0] jcode, step;
    logic [8:0] addr_sum;

    always_comb begin
        do_judge = 1'b0;
        jcode    = J_MISS;
        step     = 2'd0;
        go_hold  = 1'b0;
        go_done  = 1'b0;
        case (state)
            S_PLAY: begin
                if (key_1 == 16'h0000) begin
                    go_done = 1'b1;
                end else if (head_type == T_HEND) begin
                    step = 2'd1;                        // orphan hold-end
                end else if (is_late) begin
                    // Late miss beats a coincident press; the press is lost.
                    do_judge = 1'b1;
                    jcode    = J_MISS;
                    step     = (head_type == T_HSTART) ? 2'd2 : 2'd1;
                end else if (press && in_good) begin
                    do_judge = 1'b1;
                    jcode    = win_code;
                    step     = 2'd1;
                    go_hold  = (head_type == T_HSTART);
                end
            end
            S_HOLD: begin
                if (key_1 == 16'h0000) begin
                    go_done = 1'b1;
                end else if (!delta[14]) begin
                    // Reached the hold-end time: PERFECT whether held or
                    // released this very cycle.
                    do_judge = 1'b1;
                    jcode    = J_PERFECT;
                    step     = 2'd1;
                end else if (!key_in) begin
                    do_judge = 1'b1;
                    jcode    = (delta < NGW_S) ? J_MISS : win_code;
                    step     = 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign addr_sum = {1'b0, addr} + {7'd0, step};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            key_q       <= 1'b0;
            addr        <= 8'd0;
            song_time   <= 14'd0;
            combo       <= 10'd0;
            judge_valid <= 1'b0;
            judge_code  <= 2'b00;
        end else begin
            key_q       <= key_in;
            judge_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_PLAY;
                        addr      <= 8'd0;
                        song_time <= 14'd0;
                        combo     <= 10'd0;
                    end
                end
                default: begin
                    // d above used the pre-increment song_time.
                    if (frame_tick)
                        song_time <= song_time + 14'd1;
                    if (do_judge) begin
                        judge_valid <= 1'b1;
                        judge_code  <= jcode;
                        if (jcode == J_MISS)
                            combo <= 10'd0;
                        else if (!(&combo))
                            combo <= combo + 10'd1;
                    end
                    if (go_done) begin
                        state <= S_DONE;
                    end else if (step != 2'd0) begin
                        if (addr_sum[8]) begin
                            addr  <= 8'hFF;
                            state <= S_DONE;
                        end else begin
                            addr  <= addr_sum[7:0];
                            state <= go_hold ? S_HOLD : S_PLAY;
                        end
                    end
                end
            endcase
        end
    end

    assign hold_active = (state == S_HOLD);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_lane_judge.sv
`timescale 1ns/1ps
module tb_lane_judge;

    localparam logic [1:0] P = 2'b01, G = 2'b10, M = 2'b11;

    logic        Clk = 1'b0;
    logic        Reset_n, frame_tick, start, key_in;
    logic [15:0] key_1, key_2;
    logic [7:0]  addr;
    logic [13:0] song_time;
    logic        judge_valid, hold_active, done;
    logic [1:0]  judge_code;
    logic [9:0]  combo;

    lane_judge #(.PERFECT_WIN(3), .GOOD_WIN(6)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
        .key_in(key_in), .key_1(key_1), .key_2(key_2), .addr(addr),
        .song_time(song_time), .judge_valid(judge_valid), .judge_code(judge_code),
        .combo(combo), .hold_active(hold_active), .done(done)
    );

    always #5 Clk = ~Clk;

    // Combinational chart ROM
    logic [15:0] rom [0:255];
    assign key_1 = rom[addr];
    assign key_2 = rom[addr + 8'd1];

    typedef struct {
        logic [1:0] code;
        logic [9:0] combo;
        logic [7:0] addr;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0, n_judge = 0;
    int exp_combo = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Combo model: hits count up, a miss clears.
    task automatic exp_judge(input logic [1:0] code, input logic [7:0] a);
        exp_t e;
        if (code == M) exp_combo = 0;
        else           exp_combo++;
        e.code  = code;
        e.combo = 10'(exp_combo);
        e.addr  = a;
        sb.push_back(e);
    endtask

    task automatic wait_time(input int t);
        int n = 0;
        @(negedge Clk);
        while (song_time != 14'(t) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        if (song_time != 14'(t)) chk("wait_time_timeout", 32'(song_time), 32'(t));
    endtask

    task automatic press(input int t);
        wait_time(t);
        key_in = 1'b1;
        repeat (2) @(negedge Clk);
        key_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    // Frame strobe every 4 clocks
    initial begin
        frame_tick = 1'b0;
        forever begin
            repeat (3) @(negedge Clk);
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
    end

    // Judgement monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Reset_n && judge_valid) begin
                n_judge++;
                if (sb.size() == 0) begin
                    chk("unexpected_judge", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("judge_code",  32'(judge_code), 32'(e.code));
                    chk("judge_combo", 32'(combo),      32'(e.combo));
                    chk("judge_addr",  32'(addr),       32'(e.addr));
                end
            end
        end
    end

    initial begin
        int nj;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h0032;            // tap 50
        rom[1]  = 16'h0064;            // tap 100
        rom[2]  = 16'h0078;            // tap 120
        rom[3]  = 16'h4000 | 16'd200;  // hold 200..260
        rom[4]  = 16'h8000 | 16'd260;
        rom[5]  = 16'h4000 | 16'd300;  // hold 300..340 (broken)
        rom[6]  = 16'h8000 | 16'd340;
        rom[7]  = 16'h4000 | 16'd380;  // hold 380..420 (never pressed)
        rom[8]  = 16'h8000 | 16'd420;
        rom[9]  = 16'd450;             // tap 450
        rom[10] = 16'h8000 | 16'd470;  // orphan hold-end
        rom[11] = 16'h0000;            // end of chart

        Reset_n = 1'b0; start = 1'b0; key_in = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_song_time", 32'(song_time), 0);
        chk("rst_combo", 32'(combo), 0);
        chk("rst_judge", 32'({judge_valid, judge_code}), 0);
        chk("rst_flags", 32'({hold_active, done}), 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("start_song_time", 32'(song_time), 0);
        chk("start_done", 32'(done), 0);

        // Tap perfect
        exp_judge(P, 8'd1);
        press(52);
        wait_drain();

        // Tap good, then late miss
        exp_judge(G, 8'd2);
        press(106);
        exp_judge(M, 8'd3);
        wait_drain();
        repeat (5) @(negedge Clk);
        chk("code_held", 32'(judge_code), 32'(M));
        chk("valid_pulse", 32'(judge_valid), 0);

        // Hold held to end
        exp_judge(P, 8'd4);
        wait_time(199);
        key_in = 1'b1;
        wait_drain();
        chk("hold_active_on", 32'(hold_active), 1);
        exp_judge(P, 8'd5);
        wait_drain();
        chk("hold_active_off", 32'(hold_active), 0);
        @(negedge Clk);
        key_in = 1'b0;

        // Hold broken by early release
        exp_judge(P, 8'd6);
        wait_time(300);
        key_in = 1'b1;
        wait_drain();
        chk("hold2_active", 32'(hold_active), 1);
        exp_judge(M, 8'd7);
        wait_time(320);
        key_in = 1'b0;
        wait_drain();
        chk("hold2_released", 32'(hold_active), 0);

        // Unpressed hold-start skips its hold-end
        exp_judge(M, 8'd9);
        wait_drain();

        // Early press ignored, re-press judged
        nj = n_judge;
        press(440);
        repeat (4) @(negedge Clk);
        chk("early_press_ignored", 32'(n_judge), 32'(nj));
        exp_judge(P, 8'd10);
        press(450);
        wait_drain();

        // Orphan hold-end skipped, end marker reached
        repeat (4) @(negedge Clk);
        chk("done_set", 32'(done), 1);
        chk("done_addr", 32'(addr), 11);

        // Restart
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("restart_song_time", 32'(song_time), 0);
        chk("restart_addr", 32'(addr), 0);
        chk("restart_combo", 32'(combo), 0);
        chk("restart_done", 32'(done), 0);
        exp_combo = 0;
        exp_judge(P, 8'd1);
        press(52);
        exp_judge(P, 8'd2);
        press(100);
        exp_judge(P, 8'd3);
        press(120);
        exp_judge(P, 8'd4);
        wait_time(200);
        key_in = 1'b1;
        wait_drain();
        chk("restart_hold_active", 32'(hold_active), 1);

        // Async reset mid-HOLD, between clock edges
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_addr_time_combo", 32'({addr, song_time, combo}), 0);
        chk("arst_judge", 32'({judge_valid, judge_code}), 0);
        chk("arst_flags", 32'({hold_active, done}), 0);
        key_in = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
